// File: rtl/gstmcu_pkg.sv
// Shared constants for the GSTMCU video counter port: register indices,
// byte-lane positions and the default address width.
package gstmcu_pkg;

  localparam int DEFAULT_AW = 22;

  localparam logic [2:0] VB_HI  = 3'd0;
  localparam logic [2:0] VB_MID = 3'd1;
  localparam logic [2:0] VB_LO  = 3'd2;
  localparam logic [2:0] VC_HI  = 3'd3;
  localparam logic [2:0] VC_MID = 3'd4;
  localparam logic [2:0] VC_LO  = 3'd5;
  localparam logic [2:0] LOFF   = 3'd6;

  localparam int LANE_W  = 8;
  localparam int MID_LSB = 8;
  localparam int HI_LSB  = 16;

  // Bits of the hi byte that exist for a given address width (AW 17..24).
  function automatic logic [LANE_W-1:0] hi_lane_mask(input int aw);
    return LANE_W'((32'd1 << (aw - HI_LSB)) - 32'd1);
  endfunction

endpackage

// File: rtl/gstmcu_byte_reg.sv
// 8-bit CPU-writable register with write enable and asynchronous clear.
module gstmcu_byte_reg (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 8'h00;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gstmcu_vcnt_port.sv
// Video base/offset register port and running video DMA address counter
// with a coherent three-byte read snapshot.
module gstmcu_vcnt_port
  import gstmcu_pkg::*;
#(
  parameter int AW  = DEFAULT_AW,
  parameter bit STE = 1'b1
) (
  input  logic          c,
  input  logic          xr,
  input  logic          cs,
  input  logic          rw,
  input  logic [2:0]    addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          dvalid,
  input  logic          inc,
  input  logic          vsync,
  input  logic          de_end,
  output logic [AW-2:0] vaddr
);

  localparam logic [7:0] HI_MASK = hi_lane_mask(AW);

  logic          w_rd;
  logic          w_wr;
  logic          w_cwr;
  logic          w_rd_hi;
  logic          w_rd_lo;
  logic [7:0]    w_bhi;
  logic [7:0]    w_bmid;
  logic [7:0]    w_blo;
  logic [7:0]    w_loff;
  logic [AW-1:0] w_base;
  logic [9:0]    w_step;
  logic [AW-1:0] w_cnt_add;
  logic [AW-1:0] w_cnt_wr;
  logic [7:0]    w_rdata;

  logic [AW-1:0] r_cnt;
  // Only mid/lo are ever served from the snapshot; hi is read live.
  logic [15:0]   r_snap;
  logic          r_snap_v;
  logic [7:0]    r_dout;
  logic          r_dvalid;

  assign w_rd    = cs & rw;
  assign w_wr    = cs & ~rw;
  assign w_cwr   = STE & w_wr & ((addr == VC_HI) | (addr == VC_MID) | (addr == VC_LO));
  assign w_rd_hi = w_rd & (addr == VC_HI);
  assign w_rd_lo = w_rd & (addr == VC_LO);

  gstmcu_byte_reg u_base_hi (
    .i_clk   (c),
    .i_rst_n (xr),
    .i_we    (w_wr & (addr == VB_HI)),
    .i_d     (din & HI_MASK),
    .o_q     (w_bhi)
  );

  gstmcu_byte_reg u_base_mid (
    .i_clk   (c),
    .i_rst_n (xr),
    .i_we    (w_wr & (addr == VB_MID)),
    .i_d     (din),
    .o_q     (w_bmid)
  );

  // ST parts have no base low byte: it stays at its cleared value.
  gstmcu_byte_reg u_base_lo (
    .i_clk   (c),
    .i_rst_n (xr),
    .i_we    (STE & w_wr & (addr == VB_LO)),
    .i_d     ({din[7:1], 1'b0}),
    .o_q     (w_blo)
  );

  gstmcu_byte_reg u_loff (
    .i_clk   (c),
    .i_rst_n (xr),
    .i_we    (w_wr & (addr == LOFF)),
    .i_d     (din),
    .o_q     (w_loff)
  );

  assign w_base    = {w_bhi[AW-HI_LSB-1:0], w_bmid, w_blo};
  assign w_step    = (de_end ? {1'b0, w_loff, 1'b0} : 10'd0) + (inc ? 10'd2 : 10'd0);
  assign w_cnt_add = r_cnt + AW'(w_step);

  always_comb begin
    w_cnt_wr = r_cnt;
    case (addr)
      VC_HI:   w_cnt_wr = {din[AW-HI_LSB-1:0], r_cnt[HI_LSB-1:0]};
      VC_MID:  w_cnt_wr = {r_cnt[AW-1:HI_LSB], din, r_cnt[MID_LSB-1:0]};
      VC_LO:   w_cnt_wr = {r_cnt[AW-1:MID_LSB], din[7:1], 1'b0};
      default: w_cnt_wr = r_cnt;
    endcase
  end

  // vsync reload beats a CPU write, which beats the DMA/line advance.
  always_ff @(posedge c or negedge xr) begin
    if (!xr) begin
      r_cnt <= '0;
    end else if (vsync) begin
      r_cnt <= w_base;
    end else if (w_cwr) begin
      r_cnt <= w_cnt_wr;
    end else if (inc | de_end) begin
      r_cnt <= w_cnt_add;
    end
  end

  always_ff @(posedge c or negedge xr) begin
    if (!xr) begin
      r_snap   <= 16'h0000;
      r_snap_v <= 1'b0;
    end else if (vsync | w_cwr | w_rd_lo) begin
      r_snap_v <= 1'b0;
    end else if (w_rd_hi) begin
      r_snap   <= r_cnt[15:0];
      r_snap_v <= 1'b1;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    case (addr)
      VB_HI:   w_rdata = w_bhi;
      VB_MID:  w_rdata = w_bmid;
      VB_LO:   w_rdata = STE ? w_blo : 8'h00;
      VC_HI:   w_rdata = 8'(r_cnt[AW-1:HI_LSB]);
      VC_MID:  w_rdata = r_snap_v ? r_snap[15:8] : r_cnt[HI_LSB-1:MID_LSB];
      VC_LO:   w_rdata = r_snap_v ? r_snap[7:0] : r_cnt[MID_LSB-1:0];
      LOFF:    w_rdata = w_loff;
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge c or negedge xr) begin
    if (!xr) begin
      r_dout   <= 8'h00;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= w_rd;
      if (w_rd) begin
        r_dout <= w_rdata;
      end
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign vaddr  = r_cnt[AW-1:1];

endmodule

// File: tb/tb_gstmcu_vcnt_port.sv
// Bench for gstmcu_vcnt_port: one STE=1 and one STE=0 instance driven in
// lockstep, compared against an arithmetic model of the register port.
module tb_gstmcu_vcnt_port;

  localparam int AW = 22;

  logic          c = 1'b0;
  logic          xr;
  logic          cs;
  logic          rw;
  logic [2:0]    addr;
  logic [7:0]    din;
  logic          inc;
  logic          vsync;
  logic          de_end;
  logic [7:0]    dout1, dout0;
  logic          dvalid1, dvalid0;
  logic [AW-2:0] vaddr1, vaddr0;

  always #5 c = ~c;

  gstmcu_vcnt_port #(.AW(AW), .STE(1'b1)) u_ste1 (
    .c(c), .xr(xr), .cs(cs), .rw(rw), .addr(addr), .din(din),
    .dout(dout1), .dvalid(dvalid1), .inc(inc), .vsync(vsync),
    .de_end(de_end), .vaddr(vaddr1)
  );

  gstmcu_vcnt_port #(.AW(AW), .STE(1'b0)) u_ste0 (
    .c(c), .xr(xr), .cs(cs), .rw(rw), .addr(addr), .din(din),
    .dout(dout0), .dvalid(dvalid0), .inc(inc), .vsync(vsync),
    .de_end(de_end), .vaddr(vaddr0)
  );

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = STE=1 part, index 1 = STE=0 part.
  int m_base[2];
  int m_cnt[2];
  int m_snap[2];
  bit m_sv[2];
  int m_dout[2];
  int m_loff;
  bit m_dv;

  function automatic int get_lane(int v, int lane);
    if (lane == 2) return v / 65536;
    if (lane == 1) return (v / 256) % 256;
    return v % 256;
  endfunction

  function automatic int set_lane(int v, int lane, int d);
    if (lane == 2) return (v % 65536) + (d % 64) * 65536;
    if (lane == 1) return v - ((v / 256) % 256) * 256 + d * 256;
    return v - (v % 256) + (d / 2) * 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_base[k] = 0; m_cnt[k] = 0; m_snap[k] = 0; m_sv[k] = 0; m_dout[k] = 0;
    end
    m_loff = 0;
    m_dv   = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".vaddr1"}, 32'(vaddr1), m_cnt[0] / 2);
    chk({tag, ".vaddr0"}, 32'(vaddr0), m_cnt[1] / 2);
    chk({tag, ".dvalid1"}, 32'(dvalid1), int'(m_dv));
    chk({tag, ".dvalid0"}, 32'(dvalid0), int'(m_dv));
    chk({tag, ".dout1"}, 32'(dout1), m_dout[0]);
    chk({tag, ".dout0"}, 32'(dout0), m_dout[1]);
  endtask

  // One clock cycle with the given strobes; model advanced from pre-edge state.
  task automatic step(input bit cs_, input bit rw_, input logic [2:0] a,
                      input logic [7:0] d, input bit i_, input bit v_, input bit e_);
    int base_pre, cnt_pre, rv;
    bit ste, rd, wr, cw;
    cs = cs_; rw = rw_; addr = a; din = d; inc = i_; vsync = v_; de_end = e_;
    @(posedge c);
    rd = cs_ && rw_;
    wr = cs_ && !rw_;
    m_dv = rd;
    for (int k = 0; k < 2; k++) begin
      ste      = (k == 0);
      base_pre = m_base[k];
      cnt_pre  = m_cnt[k];
      if (rd) begin
        case (int'(a))
          0: rv = get_lane(base_pre, 2);
          1: rv = get_lane(base_pre, 1);
          2: rv = ste ? get_lane(base_pre, 0) : 0;
          3: rv = get_lane(cnt_pre, 2);
          4: rv = get_lane(m_sv[k] ? m_snap[k] : cnt_pre, 1);
          5: rv = get_lane(m_sv[k] ? m_snap[k] : cnt_pre, 0);
          6: rv = m_loff;
          default: rv = 0;
        endcase
        m_dout[k] = rv;
      end
      if (wr && a == 3'd0) m_base[k] = set_lane(base_pre, 2, int'(d));
      if (wr && a == 3'd1) m_base[k] = set_lane(base_pre, 1, int'(d));
      if (wr && a == 3'd2 && ste) m_base[k] = set_lane(base_pre, 0, int'(d));
      cw = wr && ste && a >= 3'd3 && a <= 3'd5;
      if (v_) begin
        m_cnt[k] = base_pre;
        m_sv[k]  = 0;
      end else if (cw) begin
        m_cnt[k] = set_lane(cnt_pre, 5 - int'(a), int'(d));
        m_sv[k]  = 0;
      end else begin
        m_cnt[k] = (cnt_pre + 2 * int'(i_) + 2 * m_loff * int'(e_)) % (1 << AW);
        if (rd && a == 3'd5) m_sv[k] = 0;
        else if (rd && a == 3'd3) begin
          m_snap[k] = cnt_pre;
          m_sv[k]   = 1;
        end
      end
    end
    if (wr && a == 3'd6) m_loff = int'(d);
    #1;
    check_outputs("step");
  endtask

  task automatic idle();               step(0, 0, 3'd0, 8'h00, 0, 0, 0); endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d); step(1, 0, a, d, 0, 0, 0); endtask
  task automatic rd(input logic [2:0] a); step(1, 1, a, 8'h00, 0, 0, 0); endtask
  task automatic pulse_vsync();        step(0, 0, 3'd0, 8'h00, 0, 1, 0); endtask
  task automatic pulse_inc();          step(0, 0, 3'd0, 8'h00, 1, 0, 0); endtask

  initial begin
    xr = 1'b0; cs = 0; rw = 0; addr = 3'd0; din = 8'h00; inc = 0; vsync = 0; de_end = 0;
    model_reset();
    repeat (2) @(posedge c);
    #1;
    check_outputs("reset");
    @(negedge c);
    xr = 1'b1;

    // Base load and vsync reload, then read back via the counter bytes.
    wr(3'd0, 8'h07); wr(3'd1, 8'h80); wr(3'd2, 8'h00);
    pulse_vsync();
    chk("vsync_vaddr", 32'(vaddr1), 'h03C000);
    rd(3'd3); chk("rd_hi", 32'(dout1), 'h07);
    rd(3'd4); chk("rd_mid", 32'(dout1), 'h80);
    rd(3'd5); chk("rd_lo", 32'(dout1), 'h00);
    idle();   chk("dvalid_one_cycle", 32'(dvalid1), 0);

    // Word fetch advance and line offset.
    repeat (160) pulse_inc();
    chk("inc160", 32'(vaddr1), 'h03C0A0);
    wr(3'd6, 8'h04);
    step(0, 0, 3'd0, 8'h00, 1, 0, 1);
    chk("inc_de_end", 32'(vaddr1), 'h03C0A5);

    // Coherent snapshot across a multi-byte read.
    pulse_vsync();
    rd(3'd3);
    repeat (5) pulse_inc();
    rd(3'd4); chk("snap_mid", 32'(dout1), 'h80);
    rd(3'd5); chk("snap_lo", 32'(dout1), 'h00);
    rd(3'd5); chk("live_lo", 32'(dout1), 'h0A);
    rd(3'd4);

    // vsync uses the pre-write base.
    step(1, 0, 3'd0, 8'h01, 0, 1, 0);
    chk("vsync_prewrite", 32'(vaddr1), 'h03C000);
    pulse_vsync();
    chk("vsync_newbase", 32'(vaddr1), 'h00C000);

    // ST part ignores low base/counter writes; wrap at top of space.
    wr(3'd5, 8'h55); wr(3'd2, 8'h55);
    rd(3'd2); chk("ste0_base_lo", 32'(dout0), 'h00);
    rd(3'd5);
    wr(3'd0, 8'h3F); wr(3'd1, 8'hFF);
    pulse_vsync();
    repeat (127) pulse_inc();
    chk("ste0_top", 32'(vaddr0), 'h1FFFFF);
    pulse_inc();
    chk("ste0_wrap", 32'(vaddr0), 'h000000);
    wr(3'd3, 8'h3F); wr(3'd4, 8'hFF); wr(3'd5, 8'hFF);
    chk("ste1_cntwr", 32'(vaddr1), 'h1FFFFF);
    pulse_inc();
    chk("ste1_wrap", 32'(vaddr1), 'h000000);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 3) == 0, $urandom % 2, 3'($urandom % 8), 8'($urandom),
           $urandom % 2, ($urandom % 40) == 0, ($urandom % 12) == 0);
    end
    pulse_inc();
    rd(3'd6);

    // Reset arriving while a read is in flight.
    cs = 1; rw = 1; addr = 3'd3;
    @(negedge c);
    xr = 1'b0;
    #1;
    model_reset();
    check_outputs("xr_async");
    @(posedge c);
    #1;
    check_outputs("xr_held");
    cs = 0; rw = 0;
    @(negedge c);
    xr = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
